// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed Direct Form I biquad: N_CH channels share one multiplier bank, with
// per-channel history, runtime coefficients, rounding, saturation, bypass and history clear.
module iir_biquad_tdm #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 18,
    parameter int COEF_FRAC  = 16,
    parameter int STATE_FRAC = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [CH_W-1:0]          s_ch,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     bypass,
    input  logic                     clr,
    input  logic [CH_W-1:0]          clr_ch,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_data,
    output logic                     m_valid,
    output logic [CH_W-1:0]          m_ch,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_sat
);

    localparam int YW    = DATA_W + STATE_FRAC;
    localparam int PW    = YW + COEF_W;
    localparam int ACC_W = PW + 3;

    localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(1) << COEF_FRAC;
    localparam logic signed [ACC_W-1:0]  RND    = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [YW-1:0]     Y_MAX  = {1'b0, {(YW-1){1'b1}}};
    localparam logic signed [YW-1:0]     Y_MIN  = {1'b1, {(YW-1){1'b0}}};

    // Full-precision signed product; both operands sign-extended to the product width.
    function automatic logic signed [PW-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                 input logic signed [YW-1:0] v);
        logic signed [PW-1:0] ce;
        logic signed [PW-1:0] ve;
        ce = PW'(c);
        ve = PW'(v);
        return ce * ve;
    endfunction

    // Input-side samples are lifted onto the y-history grid so all five products
    // carry COEF_FRAC+STATE_FRAC fraction bits and add without alignment.
    function automatic logic signed [YW-1:0] xs(input logic [DATA_W-1:0] x);
        return {x, {STATE_FRAC{1'b0}}};
    endfunction

    // Coefficients: index 0=b0 1=b1 2=b2 3=a1 4=a2
    logic signed [COEF_W-1:0] r_coef [5];

    // Per-channel history
    logic signed [DATA_W-1:0] r_x1 [N_CH];
    logic signed [DATA_W-1:0] r_x2 [N_CH];
    logic signed [YW-1:0]     r_y1 [N_CH];
    logic signed [YW-1:0]     r_y2 [N_CH];

    // Stage 1
    logic                     r_s1_valid;
    logic [CH_W-1:0]          r_s1_ch;
    logic                     r_s1_byp;
    logic signed [DATA_W-1:0] r_s1_x;
    logic signed [DATA_W-1:0] r_s1_x1;
    logic signed [YW-1:0]     r_s1_y1;
    logic signed [PW-1:0]     r_s1_p [5];

    logic                     w_ch_ok;
    logic                     w_accept;
    logic                     w_clr_hit;
    logic [CH_W-1:0]          w_rd_ch;
    logic signed [DATA_W-1:0] w_x1;
    logic signed [DATA_W-1:0] w_x2;
    logic signed [YW-1:0]     w_y1;
    logic signed [YW-1:0]     w_y2;
    logic signed [PW-1:0]     w_p [5];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shift;
    logic                     w_ovf;
    logic signed [YW-1:0]     w_ynew;
    logic                     w_wb;

    generate
        if ((1 << CH_W) == N_CH) begin : g_ch_full
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign w_ch_ok = (s_ch < CH_W'(N_CH));
        end
    endgenerate

    // Handshake: a sample transfers on a clock edge where s_valid and s_ready are both high.
    // s_ready is low only while stage 1 holds a sample of the same channel, so that
    // channel's history writeback lands before its next sample reads it.
    // Out-of-range channels are consumed without producing an output.
    assign s_ready  = !(r_s1_valid && (r_s1_ch == s_ch));
    assign w_accept = s_valid && s_ready && w_ch_ok;

    always_comb begin
        w_rd_ch   = w_ch_ok ? s_ch : '0;
        w_clr_hit = clr && (clr_ch == s_ch);
        w_x1      = w_clr_hit ? '0 : r_x1[w_rd_ch];
        w_x2      = w_clr_hit ? '0 : r_x2[w_rd_ch];
        w_y1      = w_clr_hit ? '0 : r_y1[w_rd_ch];
        w_y2      = w_clr_hit ? '0 : r_y2[w_rd_ch];
        w_p[0]    = mul(r_coef[0], xs(s_data));
        w_p[1]    = mul(r_coef[1], xs(w_x1));
        w_p[2]    = mul(r_coef[2], xs(w_x2));
        w_p[3]    = mul(r_coef[3], w_y1);
        w_p[4]    = mul(r_coef[4], w_y2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 5; k++) begin
                r_coef[k] <= (k == 0) ? B0_ONE : '0;
            end
        end else if (cfg_we && (cfg_addr < 3'd5)) begin
            r_coef[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_byp   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_x1    <= '0;
            r_s1_y1    <= '0;
            for (int k = 0; k < 5; k++) begin
                r_s1_p[k] <= '0;
            end
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ch  <= s_ch;
                r_s1_byp <= bypass;
                r_s1_x   <= s_data;
                r_s1_x1  <= w_x1;
                r_s1_y1  <= w_y1;
                for (int k = 0; k < 5; k++) begin
                    r_s1_p[k] <= w_p[k];
                end
            end
        end
    end

    // Sum, round to the y-history LSB, then clip to YW signed.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < 5; k++) begin
            w_acc = w_acc + ACC_W'(r_s1_p[k]);
        end
        w_shift = (w_acc + RND) >>> COEF_FRAC;
        w_ovf   = !((&w_shift[ACC_W-1:YW-1]) || !(|w_shift[ACC_W-1:YW-1]));
        if (w_ovf) begin
            w_ynew = w_shift[ACC_W-1] ? Y_MIN : Y_MAX;
        end else begin
            w_ynew = w_shift[YW-1:0];
        end
        w_wb = r_s1_valid && !r_s1_byp && !(clr && (clr_ch == r_s1_ch));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr && (clr_ch == CH_W'(i))) begin
                    r_x1[i] <= '0;
                    r_x2[i] <= '0;
                    r_y1[i] <= '0;
                    r_y2[i] <= '0;
                end else if (w_wb && (r_s1_ch == CH_W'(i))) begin
                    r_x2[i] <= r_s1_x1;
                    r_x1[i] <= r_s1_x;
                    r_y2[i] <= r_s1_y1;
                    r_y1[i] <= w_ynew;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else begin
            m_valid <= r_s1_valid;
            if (r_s1_valid) begin
                m_ch   <= r_s1_ch;
                m_data <= r_s1_byp ? r_s1_x : w_ynew[YW-1:STATE_FRAC];
                m_sat  <= !r_s1_byp && w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed bench for iir_biquad_tdm: identity, decay, saturation, hazard, clear, bypass
// and mid-stream reset, with hand-computed expected outputs.
module tb_iir_biquad_tdm;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_ch;
    logic [15:0] s_data;
    logic        bypass;
    logic        clr;
    logic [1:0]  clr_ch;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic        m_valid;
    logic [1:0]  m_ch;
    logic [15:0] m_data;
    logic        m_sat;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] exp_q[$];
    logic [18:0] cap_q[$];

    iir_biquad_tdm dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_ch     (s_ch),
        .s_data   (s_data),
        .bypass   (bypass),
        .clr      (clr),
        .clr_ch   (clr_ch),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .m_valid  (m_valid),
        .m_ch     (m_ch),
        .m_data   (m_data),
        .m_sat    (m_sat)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Output capture, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (m_valid) cap_q.push_back({m_sat, m_ch, m_data});
    end

    function automatic logic [18:0] mk(input int ch, input int d, input bit sat);
        return {sat, ch[1:0], d[15:0]};
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_coef(input int addr, input int d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr[2:0];
        cfg_data = d[17:0];
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_clr(input int ch);
        @(negedge clk);
        clr    = 1'b1;
        clr_ch = ch[1:0];
        @(negedge clk);
        clr    = 1'b0;
    endtask

    // One isolated sample: checks ready, no output after one edge, output after two.
    task automatic send1(input string tag, input int ch, input int d, input logic byp,
                         input int exp_d, input logic exp_sat);
        @(negedge clk);
        s_valid = 1'b1;
        s_ch    = ch[1:0];
        s_data  = d[15:0];
        bypass  = byp;
        #1;
        check({tag, "_rdy"}, s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        bypass  = 1'b0;
        check({tag, "_lat1"}, m_valid, 0);
        @(negedge clk);
        check({tag, "_vld"}, m_valid, 1);
        check({tag, "_ch"}, m_ch, ch);
        check({tag, "_data"}, $signed(m_data), exp_d);
        check({tag, "_sat"}, m_sat, exp_sat);
    endtask

    task automatic drain(input string tag);
        check({tag, "_cnt"}, cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            check({tag, "_out"}, cap_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        cap_q.delete();
    endtask

    int t5_v  [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    int t5_ch [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    int t5_d  [13] = '{1000, 1000, 0, 0, 0, 0, 1000, 0, 0, 0, 1000, 0, 0};
    int t5_clr[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int t5_ech[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int t5_ed [12] = '{500, 500, 250, 250, 125, 125, 500, 62, 250, 31, 500, 250};

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0; bypass = 1'b0;
        clr = 1'b0; clr_ch = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_ch", m_ch, 0);
        check("rst_sat", m_sat, 0);
        reset = 1'b0;

        // T1: identity after reset
        send1("t1", 0, 1234, 1'b0, 1234, 1'b0);
        @(negedge clk);
        check("t1_pulse", m_valid, 0);

        // T2: b0=0.5, a1=0.5 impulse decay on ch2
        wr_coef(0, 32768);
        wr_coef(3, 32768);
        send1("t2_0", 2, 1000, 1'b0, 500, 1'b0);
        send1("t2_1", 2, 0, 1'b0, 250, 1'b0);
        send1("t2_2", 2, 0, 1'b0, 125, 1'b0);
        send1("t2_3", 2, 0, 1'b0, 62, 1'b0);
        send1("t2_4", 2, 0, 1'b0, 31, 1'b0);

        // T3: b0 near 2.0 saturates at both rails
        wr_coef(0, 131071);
        wr_coef(3, 0);
        send1("t3_pos", 1, 32767, 1'b0, 32767, 1'b1);
        send1("t3_neg", 1, -32768, 1'b0, -32768, 1'b1);
        send1("t3_mid", 1, 100, 1'b0, 200, 1'b0);

        // T4: same-channel hazard, then back-to-back alternating channels
        wr_coef(0, 65536);
        cap_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_ch    = 2'd3;
            s_data  = 16'(200 + i);
            #1;
            check("t4_rdy_same", s_ready, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) exp_q.push_back(mk(3, 200 + i, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_ch    = 2'(i % 2);
            s_data  = 16'(100 + i);
            #1;
            check("t4_rdy_alt", s_ready, 1);
            exp_q.push_back(mk(i % 2, 100 + i, 1'b0));
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        drain("t4");

        // T5: interleaved decay on ch0/ch1 with clears
        wr_coef(0, 32768);
        wr_coef(3, 32768);
        pulse_clr(0);
        pulse_clr(1);
        cap_q.delete();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            s_valid = t5_v[i][0];
            s_ch    = t5_ch[i][1:0];
            s_data  = t5_d[i][15:0];
            clr     = t5_clr[i][0];
            clr_ch  = 2'd0;
            #1;
            if (t5_v[i] != 0) check("t5_rdy", s_ready, 1);
        end
        for (int i = 0; i < 12; i++) exp_q.push_back(mk(t5_ech[i], t5_ed[i], 1'b0));
        @(negedge clk);
        s_valid = 1'b0;
        clr     = 1'b0;
        repeat (3) @(negedge clk);
        drain("t5");

        // T6: bypass leaves history alone, decay then continues
        send1("t6_byp", 0, 777, 1'b1, 777, 1'b0);
        send1("t6_cont", 0, 0, 1'b0, 125, 1'b0);

        // Mid-stream reset drops in-flight samples and restores identity
        cap_q.delete();
        @(negedge clk);
        s_valid = 1'b1;
        s_ch    = 2'd2;
        s_data  = 16'd1000;
        @(negedge clk);
        s_ch    = 2'd3;
        reset   = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_rst_drop", cap_q.size(), 0);
        check("t6_rst_data", m_data, 0);
        send1("t6_ident", 2, 1000, 1'b0, 1000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
